addsub_seq_ctrl: RTL and testbench

- Multi-word adder/subtractor sequencer.
- Reuses one 4-bit add/sub nibble datapath and processes NIBBLES*4-bit operands one nibble per cycle, LSB nibble first.
- Chains the carry between nibbles through a register.
- Handshake is start/ready/done. Result, unsigned carry/no-borrow and signed overflow are registered.
- Sits between a control unit that issues wide add/sub requests and the shared 4-bit nibble adder/subtractor.

---
 rtl/addsub_seq_pkg.sv | 15 +
 rtl/nibble_addsub.sv | 23 ++
 rtl/addsub_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_addsub_seq_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial add/sub sequencer.
package addsub_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit adder/subtractor: sum = a + (b ^ {4{op}}) + cin.
// Subtraction needs cin=1 on the first nibble; the caller owns that.
module nibble_addsub
  import addsub_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                op,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] full;

  assign full = {1'b0, a}
              + {1'b0, b ^ {NIBBLE_W{op}}}
              + {{NIBBLE_W{1'b0}}, cin};

  assign sum  = full[NIBBLE_W-1:0];
  assign cout = full[NIBBLE_W];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-word add/sub sequencer: one shared nibble datapath, LSB nibble first.
// start..done spans NIBBLES+1 edges; starts outside IDLE are dropped.
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         op_in,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a_in,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b_in,
  output logic                         ready_out,
  output logic                         done_out,
  output logic [NIBBLE_W*NIBBLES-1:0]  result_out,
  output logic                         carry_out,
  output logic                         overflow_out
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state_q, state_d;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, b_q, work_q, work_d;
  logic                             op_q;
  logic                             cy_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [W-1:0]                     result_q;
  logic                             carry_q;
  logic                             ovf_q;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                last_nib;
  logic                a_msb, bx_msb, r_msb;

  nibble_addsub u_nibble (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .op   (op_q),
    .cin  (cy_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign last_nib = (idx_q == LAST_IDX);

  // Working result with the current nibble merged in, so the final edge can
  // publish the complete word directly.
  always_comb begin
    work_d        = work_q;
    work_d[idx_q] = nib_sum;
  end

  assign a_msb  = a_q[NIBBLES-1][NIBBLE_W-1];
  assign bx_msb = b_q[NIBBLES-1][NIBBLE_W-1] ^ op_q;
  assign r_msb  = work_d[NIBBLES-1][NIBBLE_W-1];

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    done_out  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        if (start_in) state_d = RUN;
      end
      RUN: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      cy_q     <= 1'b0;
      idx_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            a_q    <= a_in;
            b_q    <= b_in;
            op_q   <= op_in;
            cy_q   <= op_in;   // subtract = A + ~B + 1
            idx_q  <= '0;
            work_q <= '0;
          end
        end
        RUN: begin
          work_q <= work_d;
          cy_q   <= nib_cout;
          idx_q  <= idx_q + IDX_W'(1);
          if (last_nib) begin
            result_q <= work_d;
            carry_q  <= nib_cout;
            ovf_q    <= (a_msb == bx_msb) && (r_msb != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign result_out   = result_q;
  assign carry_out    = carry_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed-vector bench for addsub_seq_ctrl at NIBBLES=4.
module tb_addsub_seq_ctrl;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b1;
  logic        start_in = 1'b0;
  logic        op_in    = 1'b0;
  logic [15:0] a_in     = '0;
  logic [15:0] b_in     = '0;
  logic        ready_out;
  logic        done_out;
  logic [15:0] result_out;
  logic        carry_out;
  logic        overflow_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  addsub_seq_ctrl #(.NIBBLES(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .op_in        (op_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .ready_out    (ready_out),
    .done_out     (done_out),
    .result_out   (result_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Issues one operation from IDLE and checks latency and results.
  // done is expected after the 4th edge past the accepting edge.
  task automatic do_op(input string tag, input logic op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_r,
                       input logic exp_c, input logic exp_v);
    int lat;
    start_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    tick;
    start_in = 1'b0;
    lat = 0;
    while (!done_out && lat < 20) begin
      tick;
      lat++;
    end
    expect_eq({tag, ".lat"},  lat, 4);
    expect_eq({tag, ".res"},  result_out, exp_r);
    expect_eq({tag, ".cy"},   carry_out, exp_c);
    expect_eq({tag, ".ovf"},  overflow_out, exp_v);
    tick;
    expect_eq({tag, ".rdy"},  ready_out, 1'b1);
  endtask

  initial begin
    int dones;
    int lat;

    // Reset values, held three cycles
    rst_in = 1'b1;
    tick;
    expect_eq("rst.rdy",  ready_out, 1'b1);
    expect_eq("rst.done", done_out, 1'b0);
    expect_eq("rst.res",  result_out, 16'h0000);
    expect_eq("rst.cy",   carry_out, 1'b0);
    expect_eq("rst.ovf",  overflow_out, 1'b0);
    tick;
    tick;
    rst_in = 1'b0;
    tick;
    expect_eq("rel.rdy",  ready_out, 1'b1);
    expect_eq("rel.done", done_out, 1'b0);

    // Add/sub, ripple and overflow corners
    do_op("add1",  1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    do_op("sub1",  1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    do_op("ripl",  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    do_op("povf",  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    do_op("novf",  1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // Busy protection: start held high through RUN/DONE with new operands
    start_in = 1'b1; op_in = 1'b0; a_in = 16'h0001; b_in = 16'h0001;
    tick;
    a_in = 16'hAAAA; op_in = 1'b1;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (done_out) begin
        dones++;
        expect_eq("busy.res1", result_out, 16'h0002);
      end
    end
    expect_eq("busy.ndone", dones, 1);
    expect_eq("busy.idle",  ready_out, 1'b1);
    tick;
    start_in = 1'b0;
    expect_eq("busy.acc",   ready_out, 1'b0);
    lat = 0;
    while (!done_out && lat < 20) begin
      tick;
      lat++;
    end
    expect_eq("busy.lat2",  lat, 4);
    expect_eq("busy.res2",  result_out, 16'hAAA9);
    expect_eq("busy.cy2",   carry_out, 1'b1);
    expect_eq("busy.ovf2",  overflow_out, 1'b0);
    tick;

    // Reset during the second RUN cycle aborts the operation
    do_op("pre", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    start_in = 1'b1; op_in = 1'b0; a_in = 16'h1111; b_in = 16'h2222;
    tick;
    start_in = 1'b0;
    tick;
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    expect_eq("abort.rdy",  ready_out, 1'b1);
    expect_eq("abort.res",  result_out, 16'h0000);
    expect_eq("abort.cy",   carry_out, 1'b0);
    expect_eq("abort.ovf",  overflow_out, 1'b0);
    expect_eq("abort.done", done_out, 1'b0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done_out) dones++;
    end
    expect_eq("abort.ndone", dones, 0);
    do_op("post", 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);

    // Outputs hold while idle inputs toggle
    do_op("hold0", 1'b1, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      a_in  = 16'(i * 16'h1357);
      b_in  = 16'(16'hFFFF - i * 16'h0421);
      op_in = i[0];
      tick;
      expect_eq("hold.res", result_out, 16'h000F);
      expect_eq("hold.cy",  carry_out, 1'b1);
      expect_eq("hold.ovf", overflow_out, 1'b0);
      if (done_out) dones++;
    end
    expect_eq("hold.ndone", dones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
